// File: rtl/frame_coproc_pkg.sv
// Shared types and constants for the frame coprocessor input path.
// Holds the arbiter state encoding and common widths.
package frame_coproc_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BEAT_CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } arbState_t;

endpackage

// File: rtl/frame_rr_picker.sv
// Combinational round-robin picker: first set candidate after lastGrant.
// Ports: candidates, lastGrant in; found, index out.
module frame_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] candidates,
    input  logic [IDX_W-1:0]   lastGrant,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    int idx;

    // Offsets 1..NUM_REQ, so lastGrant itself is checked last.
    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(lastGrant) + k) % NUM_REQ;
            if (!found && candidates[idx]) begin
                found = 1'b1;
                index = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Frame-granular round-robin arbiter with a per-frame beat limit.
// Ports: req* streams in, dataOut* stream out, enableMask, maxFrameBeats,
// status grantIndex, busy, framesForwarded, overrunError.
module frame_stream_arbiter
    import frame_coproc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   reqData,
    input  logic [NUM_REQ-1:0]              reqTValid,
    output logic [NUM_REQ-1:0]              reqTReady,
    input  logic [NUM_REQ-1:0]              reqTLast,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] reqTStrb,
    output logic [DATA_WIDTH-1:0]           dataOut,
    output logic                            dataOutTValid,
    input  logic                            dataOutTReady,
    output logic                            dataOutTLast,
    output logic [DATA_WIDTH/8-1:0]         dataOutTStrb,
    input  logic [NUM_REQ-1:0]              enableMask,
    input  logic [BEAT_CNT_W-1:0]           maxFrameBeats,
    output logic [$clog2(NUM_REQ)-1:0]      grantIndex,
    output logic                            busy,
    output logic [31:0]                     framesForwarded,
    output logic                            overrunError
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;

    arbState_t              state;
    logic [IDX_W-1:0]       lastGrant;
    logic [BEAT_CNT_W-1:0]  beatCount;

    logic                   pickFound;
    logic [IDX_W-1:0]       pickIndex;

    logic                   gValid;
    logic                   gLast;
    logic [DATA_WIDTH-1:0]  gData;
    logic [STRB_W-1:0]      gStrb;
    logic                   limitHit;
    logic                   xfer;

    frame_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) picker (
        .candidates (reqTValid & enableMask),
        .lastGrant  (lastGrant),
        .found      (pickFound),
        .index      (pickIndex)
    );

    always_comb begin
        gValid = reqTValid[grantIndex];
        gLast  = reqTLast[grantIndex];
        gData  = reqData[int'(grantIndex)*DATA_WIDTH +: DATA_WIDTH];
        gStrb  = reqTStrb[int'(grantIndex)*STRB_W +: STRB_W];
    end

    // The current beat is the last one the limit allows.
    assign limitHit = (maxFrameBeats != '0) &&
                      (beatCount == maxFrameBeats - 1'b1);
    assign xfer     = (state == STREAM) && gValid && dataOutTReady;
    assign busy     = (state != IDLE);

    always_comb begin
        reqTReady     = '0;
        dataOut       = '0;
        dataOutTStrb  = '0;
        dataOutTLast  = 1'b0;
        dataOutTValid = 1'b0;
        unique case (state)
            STREAM: begin
                dataOut               = gData;
                dataOutTStrb          = gStrb;
                dataOutTLast          = gLast | limitHit;
                dataOutTValid         = gValid;
                reqTReady[grantIndex] = dataOutTReady;
            end
            // Swallow the tail of a truncated frame.
            DRAIN: reqTReady[grantIndex] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            grantIndex      <= '0;
            lastGrant       <= IDX_W'(NUM_REQ - 1);
            beatCount       <= '0;
            framesForwarded <= '0;
            overrunError    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pickFound) begin
                        grantIndex <= pickIndex;
                        beatCount  <= '0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        beatCount <= beatCount + 1'b1;
                        if (gLast) begin
                            framesForwarded <= framesForwarded + 1;
                            lastGrant       <= grantIndex;
                            state           <= IDLE;
                        end else if (limitHit) begin
                            framesForwarded <= framesForwarded + 1;
                            overrunError    <= 1'b1;
                            state           <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (gValid && gLast) begin
                        lastGrant <= grantIndex;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Directed bench for frame_stream_arbiter with a per-requester frame model.
// Expected beats and cycles are hand-derived per scenario.
module tb_frame_stream_arbiter;
    import frame_coproc_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N*DW-1:0] reqData = '0;
    logic [N-1:0]    reqTValid = '0;
    logic [N-1:0]    reqTReady;
    logic [N-1:0]    reqTLast = '0;
    logic [N*SW-1:0] reqTStrb = '0;
    logic [DW-1:0]   dataOut;
    logic            dataOutTValid;
    logic            dataOutTReady = 1'b1;
    logic            dataOutTLast;
    logic [SW-1:0]   dataOutTStrb;
    logic [N-1:0]    enableMask = 4'hF;
    logic [15:0]     maxFrameBeats = '0;
    logic [1:0]      grantIndex;
    logic            busy;
    logic [31:0]     framesForwarded;
    logic            overrunError;

    frame_stream_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .reqData         (reqData),
        .reqTValid       (reqTValid),
        .reqTReady       (reqTReady),
        .reqTLast        (reqTLast),
        .reqTStrb        (reqTStrb),
        .dataOut         (dataOut),
        .dataOutTValid   (dataOutTValid),
        .dataOutTReady   (dataOutTReady),
        .dataOutTLast    (dataOutTLast),
        .dataOutTStrb    (dataOutTStrb),
        .enableMask      (enableMask),
        .maxFrameBeats   (maxFrameBeats),
        .grantIndex      (grantIndex),
        .busy            (busy),
        .framesForwarded (framesForwarded),
        .overrunError    (overrunError)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nErrors = 0;

    int frameLen[N];
    int framesLeft[N];
    int beatNo[N];
    int fid[N];

    int          cyc;
    logic [31:0] dataLog[64];
    logic        validLog[64];
    logic        busyLog[64];
    int          logCyc[$];
    logic [31:0] logData[$];
    logic        logLast[$];
    int          readyPat[$];
    logic        saw2;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beatVal(int r, int f, int b);
        return {8'(r), 8'(f), 16'(b)};
    endfunction

    function automatic logic [31:0] dataAt(int k);
        return (k < logData.size()) ? logData[k] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] cycAt(int k);
        return (k < logCyc.size()) ? 32'(logCyc[k]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] lastAt(int k);
        return (k < logLast.size()) ? 32'(logLast[k]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < N; i++) begin
            frameLen[i]   = 1;
            framesLeft[i] = 0;
            beatNo[i]     = 0;
            fid[i]        = 0;
        end
    endtask

    task automatic setFrames(input int r, input int len, input int cnt);
        frameLen[r]   = len;
        framesLeft[r] = cnt;
        beatNo[r]     = 0;
        fid[r]        = 0;
    endtask

    task automatic clearLogs();
        cyc = 0;
        logCyc.delete();
        logData.delete();
        logLast.delete();
        readyPat.delete();
        saw2 = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            reqTValid[i]         = framesLeft[i] > 0;
            reqData[i*DW +: DW]  = beatVal(i, fid[i], beatNo[i]);
            reqTLast[i]          = beatNo[i] == frameLen[i] - 1;
            reqTStrb[i*SW +: SW] = 4'(beatNo[i] + 1);
        end
        dataOutTReady = (cyc < readyPat.size()) ? readyPat[cyc][0] : 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0] hs;
        logic rstNow;
        drive();
        #2;
        if (cyc < 64) begin
            dataLog[cyc]  = dataOut;
            validLog[cyc] = dataOutTValid;
            busyLog[cyc]  = busy;
        end
        if (dataOutTValid && dataOutTReady) begin
            logCyc.push_back(cyc);
            logData.push_back(dataOut);
            logLast.push_back(dataOutTLast);
        end
        if (reqTReady[2]) saw2 = 1'b1;
        hs     = reqTValid & reqTReady;
        rstNow = reset;
        @(posedge clock);
        #1;
        cyc++;
        if (rstNow) begin
            clearModel();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    beatNo[i]++;
                    if (beatNo[i] == frameLen[i]) begin
                        beatNo[i] = 0;
                        framesLeft[i]--;
                        fid[i]++;
                    end
                end
            end
        end
    endtask

    task automatic runTicks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearModel();
        tick();
        tick();
        reset = 1'b0;
        clearLogs();
    endtask

    initial begin
        clearModel();
        clearLogs();

        // Reset values
        doReset();
        drive();
        #1;
        checkVal("rst busy", 32'(busy), 0);
        checkVal("rst grant", 32'(grantIndex), 0);
        checkVal("rst frames", framesForwarded, 0);
        checkVal("rst overrun", 32'(overrunError), 0);
        checkVal("rst reqReady", 32'(reqTReady), 0);
        checkVal("rst valid", 32'(dataOutTValid), 0);
        checkVal("rst last", 32'(dataOutTLast), 0);
        checkVal("rst strb", 32'(dataOutTStrb), 0);
        checkVal("rst data", dataOut, 0);

        // Requesters 0 and 2, one 3-beat frame each
        setFrames(0, 3, 1);
        setFrames(2, 3, 1);
        runTicks(10);
        checkVal("s2 beats", 32'(logData.size()), 6);
        for (int k = 0; k < 6; k++) begin
            checkVal($sformatf("s2 data %0d", k), dataAt(k),
                     k < 3 ? beatVal(0, 0, k) : beatVal(2, 0, k - 3));
            checkVal($sformatf("s2 cyc %0d", k), cycAt(k),
                     k < 3 ? 32'(k + 1) : 32'(k + 2));
            checkVal($sformatf("s2 last %0d", k), lastAt(k),
                     32'(k == 2 || k == 5));
        end
        checkVal("s2 frames", framesForwarded, 2);
        checkVal("s2 grant", 32'(grantIndex), 2);

        // All four continuously valid, 2-beat frames
        doReset();
        for (int i = 0; i < N; i++) setFrames(i, 2, 2);
        runTicks(15);
        for (int k = 0; k < 10; k++) begin
            checkVal($sformatf("s3 data %0d", k), dataAt(k),
                     beatVal((k / 2) % 4, (k / 2) / 4, k % 2));
            checkVal($sformatf("s3 cyc %0d", k), cycAt(k),
                     32'(1 + 3 * (k / 2) + (k % 2)));
        end

        // Requester 2 masked off
        doReset();
        enableMask = 4'b1011;
        setFrames(2, 2, 1);
        setFrames(3, 2, 1);
        runTicks(8);
        checkVal("s4 beats", 32'(logData.size()), 2);
        checkVal("s4 data0", dataAt(0), beatVal(3, 0, 0));
        checkVal("s4 data1", dataAt(1), beatVal(3, 0, 1));
        checkVal("s4 ready2", 32'(saw2), 0);
        checkVal("s4 req2 left", 32'(framesLeft[2]), 1);
        checkVal("s4 frames", framesForwarded, 1);
        enableMask = 4'hF;

        // Beat limit 4 on a 6-beat frame
        doReset();
        maxFrameBeats = 16'd4;
        setFrames(1, 6, 1);
        runTicks(9);
        checkVal("s5 beats", 32'(logData.size()), 4);
        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("s5 data %0d", k), dataAt(k), beatVal(1, 0, k));
            checkVal($sformatf("s5 last %0d", k), lastAt(k), 32'(k == 3));
        end
        checkVal("s5 overrun", 32'(overrunError), 1);
        checkVal("s5 frames", framesForwarded, 1);
        checkVal("s5 drain valid5", 32'(validLog[5]), 0);
        checkVal("s5 drain valid6", 32'(validLog[6]), 0);
        checkVal("s5 drain busy6", 32'(busyLog[6]), 1);
        checkVal("s5 idle busy7", 32'(busyLog[7]), 0);
        checkVal("s5 req1 left", 32'(framesLeft[1]), 0);

        // Output stalls; limit equals frame length, so no truncation
        doReset();
        maxFrameBeats = 16'd4;
        readyPat = '{1, 1, 0, 0, 1};
        setFrames(0, 4, 1);
        runTicks(8);
        checkVal("s6 beats", 32'(logData.size()), 4);
        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("s6 data %0d", k), dataAt(k), beatVal(0, 0, k));
            checkVal($sformatf("s6 cyc %0d", k), cycAt(k),
                     k == 0 ? 32'd1 : 32'(k + 3));
            checkVal($sformatf("s6 last %0d", k), lastAt(k), 32'(k == 3));
        end
        checkVal("s6 hold2", dataLog[2], beatVal(0, 0, 1));
        checkVal("s6 hold3", dataLog[3], beatVal(0, 0, 1));
        checkVal("s6 hold valid", 32'(validLog[3]), 1);
        checkVal("s6 overrun", 32'(overrunError), 0);
        checkVal("s6 frames", framesForwarded, 1);

        // Reset on beat 2 of a 5-beat frame from requester 1
        clearLogs();
        setFrames(1, 5, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive();
        #1;
        checkVal("s7 busy", 32'(busy), 0);
        checkVal("s7 valid", 32'(dataOutTValid), 0);
        checkVal("s7 reqReady", 32'(reqTReady), 0);
        checkVal("s7 frames", framesForwarded, 0);
        checkVal("s7 grant", 32'(grantIndex), 0);
        checkVal("s7 data", dataOut, 0);
        clearLogs();
        setFrames(0, 1, 1);
        setFrames(1, 1, 1);
        runTicks(6);
        checkVal("s7 beats", 32'(logData.size()), 2);
        checkVal("s7 first", dataAt(0), beatVal(0, 0, 0));
        checkVal("s7 second", dataAt(1), beatVal(1, 0, 0));
        checkVal("s7 cyc0", cycAt(0), 1);
        checkVal("s7 cyc1", cycAt(1), 3);
        checkVal("s7 last0", lastAt(0), 1);
        checkVal("s7 frames2", framesForwarded, 2);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/frame_stream_arbiter.md
# frame_stream_arbiter

Frame-granular round-robin arbiter that shares the single FrameCoprocessor input stream among NUM_REQ AXI-Stream requesters. A grant is held from the first beat to the TLast beat of one frame, so frames never interleave. The arbiter also enforces a per-frame beat limit so a runaway requester cannot hold the coprocessor. It sits directly upstream of the coprocessor's dataIn port.

## Interface
- NUM_REQ, 4, number of requester streams (2..8)
- DATA_WIDTH, 32, data bits per beat; TStrb width is DATA_WIDTH/8
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- reqData  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- reqTValid  in  NUM_REQ  per-requester valid
- reqTReady  out  NUM_REQ  per-requester ready
- reqTLast  in  NUM_REQ  per-requester end of frame
- reqTStrb  in  NUM_REQ*DATA_WIDTH/8  per-requester byte strobes
- dataOut  out  DATA_WIDTH  to coprocessor dataIn
- dataOutTValid  out  1
- dataOutTReady  in  1
- dataOutTLast  out  1
- dataOutTStrb  out  DATA_WIDTH/8
- enableMask  in  NUM_REQ  requesters eligible for grant
- maxFrameBeats  in  16  beat limit per frame; 0 = unlimited
- grantIndex  out  $clog2(NUM_REQ)  current or last granted requester
- busy  out  1  high in STREAM or DRAIN
- framesForwarded  out  32  count of frames completed on the output (wraps)
- overrunError  out  1  sticky; set on beat-limit truncation, cleared only by reset

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: candidates = reqTValid & enableMask. If nonzero, pick the first candidate searching from lastGrant+1 modulo NUM_REQ; register grantIndex; next state STREAM. All reqTReady = 0; dataOutTValid = 0.
- STREAM: combinational pass-through from granted requester: dataOut, dataOutTStrb, dataOutTLast, dataOutTValid = reqTValid[g]; reqTReady[g] = dataOutTReady; other reqTReady = 0.
- A beat transfers when dataOutTValid && dataOutTReady. beatCount (16 bits) increments per transfer, cleared on entering STREAM.
- Transfer with reqTLast[g] = 1: framesForwarded += 1, lastGrant <= g, next state IDLE.
- Beat-limit: if maxFrameBeats != 0 and the transfer is beat number maxFrameBeats (beatCount == maxFrameBeats-1) without reqTLast: dataOutTLast forced 1 on that beat, overrunError <= 1, framesForwarded += 1, next state DRAIN.
- DRAIN: reqTReady[g] = 1, dataOutTValid = 0; granted beats discarded until one with reqTLast transfers, then lastGrant <= g, IDLE.
- enableMask and maxFrameBeats are sampled only at the IDLE decision and on each beat respectively; clearing enableMask[g] mid-frame does not abort the frame.
- Grant changes only in IDLE; no beat ever reaches the output from a non-granted requester.

## Timing
- Reset values: state IDLE, grantIndex 0, lastGrant NUM_REQ-1 (first grant searches from 0), busy 0, reqTReady 0, dataOutTValid 0, dataOutTLast 0, dataOutTStrb 0, dataOut 0, framesForwarded 0, overrunError 0, beatCount 0.
- Arbitration latency: valid seen in IDLE at cycle N -> first beat can transfer at N+1.
- Frame-to-frame bubble: exactly one IDLE cycle after each TLast transfer (or DRAIN exit).
- Data path has zero register latency in STREAM; ready/valid are combinational through the mux.
- Single-beat frame (TLast on first beat) is legal: STREAM for one cycle, IDLE next.
- maxFrameBeats = 1 with non-TLast first beat: that beat emitted with TLast, DRAIN next.
- Reset asserted mid-frame: next cycle all outputs at reset values; partial frame is abandoned, not completed.

## Structure
- Package frame_coproc_pkg: arbiter state enum (IDLE/STREAM/DRAIN), default DATA_WIDTH, beat-count width constant (16).
- One sub-module: frame_rr_picker — combinational, inputs candidates and lastGrant, outputs found flag and index; reusable by other frame schedulers.

## Test plan
- Reset, then requesters 0 and 2 each valid with 3-beat frames, enableMask 4'b1111, dataOutTReady=1 -> output frame from 0 (beats at cycles 1-3), IDLE bubble, frame from 2; framesForwarded = 2, grantIndex = 2.
- All four requesters continuously valid with 2-beat frames -> grant order 0,1,2,3,0; no interleaved beats; 3 cycles per frame.
- enableMask = 4'b1011, requester 2 valid -> never granted, reqTReady[2] stays 0; requester 3 granted.
- maxFrameBeats = 4, requester 1 sends 6-beat frame -> 4 beats out, 4th with dataOutTLast = 1, overrunError = 1, beats 5-6 consumed with dataOutTValid = 0, then IDLE.
- dataOutTReady toggled 1,0,0,1 during a frame -> beats held stable while stalled, no loss or duplication, beatCount advances only on transfers.
- reset pulsed on beat 2 of a 5-beat frame -> all outputs reset next cycle, framesForwarded = 0; new frame afterwards granted to requester 0 first.
